reg_dump_uart: RTL and testbench
================================

# reg_dump_uart

Debug reader for the processor's register-file readout port. On a start pulse it walks a range of register indices on `regin`, captures each value returned on `regout`, and transmits it over an 8N1 UART line as printable ASCII, one line per register. It sits beside the core in the board top level and connects to `regin`/`regout` and to a board TX pin.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 434: `clock` cycles per UART bit (50 MHz / 115200). Must be ≥ 2.
- `FIRST_REG`, default 0: first register index dumped.
- `LAST_REG`, default 31: last register index dumped. Constraint: `FIRST_REG` ≤ `LAST_REG` ≤ 31.

**Ports**
- `clock`, input, 1: single clock for the whole block.
- `reset`, input, 1: asynchronous, active-low.
- `start`, input, 1: request a dump; sampled on the rising edge of `clock`.
- `regin`, output, 5: register index driven to the core readout port.
- `regout`, input, 32: register value returned by the core.
- `tx`, output, 1: UART serial output, idle high.
- `busy`, output, 1: high while a dump is in progress.
- `done`, output, 1: one-cycle pulse when a dump completes.

## Operation

- **Reset (`reset`=0)**: takes effect immediately, without waiting for a clock edge.
  - `tx`=1, `busy`=0, `done`=0, `regin`=0.
  - FSM goes to IDLE; all counters and shift registers clear.
- **Line format per register**: 13 bytes, "II:HHHHHHHH" followed by CR (0x0D) and LF (0x0A).
  - II is the 2-digit hex index.
  - HHHHHHHH is the 32-bit value, most significant nibble first.
  - Hex digits are uppercase ASCII: 0–9 map to 0x30–0x39; A–F map to 0x41–0x46.
- **FSM states**:
  - IDLE: when `start`=1, load the index counter with `FIRST_REG`; go to SELECT.
  - SELECT: drive `regin` with the index; wait 2 cycles (settle); go to CAPTURE.
  - CAPTURE: latch `regout` into a 32-bit hold register; clear the char counter to 0; go to LOAD.
  - LOAD: form the byte for the current char counter value (0..12); go to START_BIT.
  - START_BIT: `tx`=0 for `CLKS_PER_BIT` cycles; go to DATA.
  - DATA: 8 bits, LSB first, each held `CLKS_PER_BIT` cycles; go to STOP_BIT.
  - STOP_BIT: `tx`=1 for `CLKS_PER_BIT` cycles. Then:
    - if char < 12: increment char counter, go to LOAD;
    - else if index < `LAST_REG`: increment index, go to SELECT;
    - else go to FINISH.
  - FINISH: pulse `done` for 1 cycle; go to IDLE.
- `busy`=1 in every state except IDLE.
- **Captured value**: `regout` is sampled exactly once per register, in CAPTURE. Changes on `regout` afterwards do not affect that register's line.
- **`regin`**: holds the current index from SELECT until the next SELECT. Returns to 0 on entering IDLE.
- **`start` while `busy`**: ignored. Not queued. No restart.
- **`start` held high**: a new dump begins on the first IDLE cycle after FINISH, so `start` is level-sensitive in IDLE.
- **Index width**: the index counter is 5 bits. Termination is by comparison with `LAST_REG`, before incrementing. With `LAST_REG`=31 the counter never wraps to 0.
- **Reset mid-operation**: aborts immediately. `tx` goes high mid-frame; the partial frame is not completed.

## Timing

- Let edge k be the edge at which `start`=1 is sampled in IDLE.
  - After edge k: `busy`=1 and `regin`=`FIRST_REG`.
  - Capture happens at edge k+3.
  - `tx` falls (start bit) after edge k+4.
- Each frame lasts exactly 10·`CLKS_PER_BIT` cycles.
- LOAD adds 1 cycle between consecutive frames of the same line. The gap between stop-bit end and the next start bit is therefore 1 cycle, during which `tx` stays high.
- Between lines: SELECT (2 cycles) plus CAPTURE plus LOAD add 4 cycles of `tx` high.
- Per register: 13·(10·`CLKS_PER_BIT` + 1) + 3 cycles.
- `done` is high during the cycle after the last stop bit ends. `busy` falls at the same edge that ends `done`.
- No combinational path from `regout` or `start` to any output. All outputs are registered.

## Test plan

1. **Reset values**: hold `reset`=0 mid-simulation with a random `start` → `tx`=1, `busy`=0, `done`=0, `regin`=0; no edge needed.
2. **Single-register dump**: `FIRST_REG`=`LAST_REG`=5, `CLKS_PER_BIT`=4, `regout`=0xDEADBEEF.
   - Expect bytes 0x30 0x35 0x3A 0x44 0x45 0x41 0x44 0x42 0x45 0x45 0x46 0x0D 0x0A.
   - Each bit lasts 4 cycles, LSB first.
   - `done` pulses once; `regin`=5 during transmit.
3. **Hex mapping and capture-once**: `regout`=0x0A0B0C0F at CAPTURE, changed to 0xFFFFFFFF one cycle later → value chars "0A0B0C0F" (0x30 0x41 0x30 0x42 0x30 0x43 0x30 0x46).
4. **Full range**: defaults except `CLKS_PER_BIT`=2; `regout`=`regin`·0x01010101 by bench model.
   - Expect 32 lines, indices 00..1F, in order.
   - After line 1F: `done`, then IDLE. No wrap to index 00.
   - Total cycles match the Timing formula.
5. **Start while busy**: pulse `start` during the third frame → line count and content unchanged, single `done`.
6. **Reset mid-frame**: assert `reset`=0 during a DATA bit → `tx`=1 immediately. After release: IDLE, and a new `start` produces a complete correct dump.

Source files
------------

// File: rtl/reg_dump_uart.sv
// Register-file dump over 8N1 UART: walks regin from FIRST_REG to LAST_REG and
// prints each value as "II:HHHHHHHH\r\n" in uppercase ASCII hex.
//
// state     | meaning
// IDLE      | waiting for start, regin parked at 0
// SELECT    | regin driven, 2-cycle settle for the readout port
// CAPTURE   | latch regout into hold register, reset char counter
// LOAD      | form the byte for the current char
// START_BIT | tx low for one bit time
// DATA      | 8 data bits, LSB first
// STOP_BIT  | tx high for one bit time, then pick next char/register/finish
// FINISH    | one-cycle done pulse
module reg_dump_uart #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIRST_REG    = 0,
    parameter int LAST_REG     = 31
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  regin,
    input  logic [31:0] regout,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SELECT    = 3'd1;
    localparam logic [2:0] CAPTURE   = 3'd2;
    localparam logic [2:0] LOAD      = 3'd3;
    localparam logic [2:0] START_BIT = 3'd4;
    localparam logic [2:0] DATA      = 3'd5;
    localparam logic [2:0] STOP_BIT  = 3'd6;
    localparam logic [2:0] FINISH    = 3'd7;

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [3:0]    char_q, char_d;
    logic [4:0]    idx_q, idx_d;
    logic [4:0]    regin_q, regin_d;
    logic [31:0]   hold_q, hold_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [7:0]    char_byte;
    logic [2:0]    nib_idx;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // chars 3..10 select hold nibbles 7..0
    assign nib_idx = 3'(4'd10 - char_q);

    always_comb begin
        case (char_q)
            4'd0:    char_byte = hex_char({3'b000, idx_q[4]});
            4'd1:    char_byte = hex_char(idx_q[3:0]);
            4'd2:    char_byte = 8'h3A;
            4'd11:   char_byte = 8'h0D;
            4'd12:   char_byte = 8'h0A;
            default: char_byte = hex_char(hold_q[{nib_idx, 2'b00} +: 4]);
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        char_d  = char_q;
        idx_d   = idx_q;
        regin_d = regin_q;
        hold_d  = hold_q;
        sh_d    = sh_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = 5'(FIRST_REG);
                    regin_d = 5'(FIRST_REG);
                    cnt_d   = CNT_ONE;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (cnt_q == '0) state_d = CAPTURE;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            CAPTURE: begin
                hold_d  = regout;
                char_d  = 4'd0;
                state_d = LOAD;
            end
            LOAD: begin
                sh_d    = char_byte;
                cnt_d   = BIT_LAST;
                state_d = START_BIT;
            end
            START_BIT: begin
                if (cnt_q == '0) begin
                    cnt_d   = BIT_LAST;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = BIT_LAST;
                    sh_d  = {1'b0, sh_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP_BIT;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            STOP_BIT: begin
                if (cnt_q == '0) begin
                    if (char_q < 4'd12) begin
                        char_d  = char_q + 4'd1;
                        state_d = LOAD;
                    end else if (idx_q < 5'(LAST_REG)) begin
                        idx_d   = idx_q + 5'd1;
                        regin_d = idx_q + 5'd1;
                        cnt_d   = CNT_ONE;
                        state_d = SELECT;
                    end else begin
                        state_d = FINISH;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            FINISH: begin
                regin_d = 5'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // outputs decoded from the next state so they come straight off flops
        tx_d = 1'b1;
        if (state_d == START_BIT) tx_d = 1'b0;
        else if (state_d == DATA) tx_d = sh_d[0];
        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            char_q  <= '0;
            idx_q   <= '0;
            regin_q <= '0;
            hold_q  <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            char_q  <= char_d;
            idx_q   <= idx_d;
            regin_q <= regin_d;
            hold_q  <= hold_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign regin = regin_q;
    assign tx    = tx_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_reg_dump_uart.sv
// Bench for reg_dump_uart: two instances (single register at 4 clk/bit, full
// range at 2 clk/bit), UART decoder popping an expected-byte scoreboard.
module tb_reg_dump_uart;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [31:0] regout_a = 32'hDEADBEEF;
    logic [31:0] regout_b;
    logic [4:0]  regin_a, regin_b;
    logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;
    logic        sel = 1'b0;

    logic        tx_m, busy_m, done_m;
    logic [4:0]  regin_m;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    typedef struct {
        logic [7:0] b;
        logic [4:0] idx;
    } exp_t;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    reg_dump_uart #(.CLKS_PER_BIT(4), .FIRST_REG(5), .LAST_REG(5)) u_dut_a (
        .clock(clock), .reset(reset), .start(start_a), .regin(regin_a),
        .regout(regout_a), .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    reg_dump_uart #(.CLKS_PER_BIT(2)) u_dut_b (
        .clock(clock), .reset(reset), .start(start_b), .regin(regin_b),
        .regout(regout_b), .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    // core model for the full-range instance
    assign regout_b = {4{3'b000, regin_b}};

    assign tx_m    = sel ? tx_b    : tx_a;
    assign busy_m  = sel ? busy_b  : busy_a;
    assign done_m  = sel ? done_b  : done_a;
    assign regin_m = sel ? regin_b : regin_a;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_hex(input logic [3:0] n);
        logic [7:0] digits [16];
        digits = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                   8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        return digits[n];
    endfunction

    task automatic push_line(input logic [4:0] idx, input logic [31:0] val);
        exp_t e;
        e.idx = idx;
        e.b = to_hex({3'b000, idx[4]}); exp_q.push_back(e);
        e.b = to_hex(idx[3:0]);         exp_q.push_back(e);
        e.b = 8'h3A;                    exp_q.push_back(e);
        for (int i = 7; i >= 0; i--) begin
            e.b = to_hex(val[i*4 +: 4]);
            exp_q.push_back(e);
        end
        e.b = 8'h0D; exp_q.push_back(e);
        e.b = 8'h0A; exp_q.push_back(e);
    endtask

    // UART decoder: checks every cycle of each bit so bit length is verified too
    initial begin
        forever begin
            @(negedge clock);
            if (reset && tx_m == 1'b0) begin
                int         cpb;
                logic [9:0] bits;
                logic       bv;
                bit         bad, aborted;
                exp_t       e;
                cpb = sel ? 2 : 4;
                bad = 0;
                aborted = 0;
                bits = '0;
                bv = 1'b0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < cpb; c++) begin
                        if (!(b == 0 && c == 0)) @(negedge clock);
                        if (!reset) begin
                            aborted = 1;
                            break;
                        end
                        if (c == 0) bv = tx_m;
                        else if (tx_m !== bv) bad = 1;
                    end
                    if (aborted) break;
                    bits[b] = bv;
                end
                if (!aborted) begin
                    chk("start_bit", 32'(bits[0]), 32'd0);
                    chk("stop_bit", 32'(bits[9]), 32'd1);
                    chk("bit_len", 32'(bad), 32'd0);
                    if (exp_q.size() == 0) begin
                        chk("extra_byte", 32'(bits[8:1]), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte", 32'(bits[8:1]), 32'(e.b));
                        chk("regin_tx", 32'(regin_m), 32'(e.idx));
                    end
                end
            end
        end
    end

    always @(negedge clock) if (done_a || done_b) done_cnt++;

    task automatic set_start(input logic s, input logic v);
        if (s) start_b = v;
        else   start_a = v;
    endtask

    task automatic run_dump(input logic s, input int exp_cycles, input int change_n,
                            input int pulse_n, input int rst_at);
        int n, first_low;
        bit got;
        @(negedge clock);
        set_start(s, 1'b1);
        @(posedge clock);
        #1;
        chk("busy_k", 32'(busy_m), 32'd1);
        chk("regin_k", 32'(regin_m), s ? 32'd0 : 32'd5);
        set_start(s, 1'b0);
        n = 0;
        first_low = -1;
        got = 0;
        while (n < exp_cycles + 50) begin
            @(posedge clock);
            n++;
            #1;
            if (tx_m == 1'b0 && first_low < 0) first_low = n;
            if (n == change_n) regout_a = 32'hFFFF_FFFF;
            if (n == pulse_n) set_start(s, 1'b1);
            if (n == pulse_n + 1) set_start(s, 1'b0);
            if (n == rst_at) begin
                reset = 1'b0;
                #1;
                chk("rst_tx", 32'(tx_m), 32'd1);
                chk("rst_busy", 32'(busy_m), 32'd0);
                chk("rst_done", 32'(done_m), 32'd0);
                chk("rst_regin", 32'(regin_m), 32'd0);
                repeat (3) @(negedge clock);
                exp_q.delete();
                reset = 1'b1;
                return;
            end
            if (done_m) begin
                got = 1;
                break;
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("cycles", 32'(n), 32'(exp_cycles));
        chk("tx_fall", 32'(first_low), 32'd4);
        @(posedge clock);
        #1;
        chk("done_width", 32'(done_m), 32'd0);
        chk("busy_end", 32'(busy_m), 32'd0);
        chk("regin_idle", 32'(regin_m), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int d0;
        // 13*(10*4+1)+3 per register for A; 32*(13*(10*2+1)+3) for B
        #1;
        reset = 1'b0;
        start_a = 1'($urandom);
        start_b = 1'($urandom);
        #2;
        chk("rst_tx_a", 32'(tx_a), 32'd1);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_done_a", 32'(done_a), 32'd0);
        chk("rst_regin_a", 32'(regin_a), 32'd0);
        chk("rst_tx_b", 32'(tx_b), 32'd1);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        repeat (3) @(negedge clock);
        start_a = 1'b0;
        start_b = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // single register DEADBEEF
        sel = 1'b0;
        d0 = done_cnt;
        push_line(5'd5, 32'hDEADBEEF);
        run_dump(1'b0, 536, -1, -1, -1);
        chk("done_count_single", 32'(done_cnt - d0), 32'd1);

        // hex letters and capture-once
        regout_a = 32'h0A0B0C0F;
        push_line(5'd5, 32'h0A0B0C0F);
        run_dump(1'b0, 536, 3, -1, -1);
        regout_a = 32'hDEADBEEF;

        // full range
        sel = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 32; i++) push_line(5'(i), {4{3'b000, 5'(i)}});
        run_dump(1'b1, 8832, -1, -1, -1);
        repeat (30) @(negedge clock);
        chk("full_no_wrap", 32'(busy_b), 32'd0);
        chk("done_count_full", 32'(done_cnt - d0), 32'd1);

        // start pulse during third frame is ignored
        sel = 1'b0;
        repeat (2) @(negedge clock);
        d0 = done_cnt;
        push_line(5'd5, 32'hDEADBEEF);
        run_dump(1'b0, 536, -1, 90, -1);
        repeat (30) @(negedge clock);
        chk("busy_no_restart", 32'(busy_a), 32'd0);
        chk("done_count_busy", 32'(done_cnt - d0), 32'd1);

        // reset during data bit 0 of the first frame, then a clean dump
        push_line(5'd5, 32'hDEADBEEF);
        run_dump(1'b0, 536, -1, -1, 9);
        repeat (2) @(negedge clock);
        chk("post_rst_busy", 32'(busy_a), 32'd0);
        d0 = done_cnt;
        regout_a = 32'h1234_5678;
        push_line(5'd5, 32'h1234_5678);
        run_dump(1'b0, 536, -1, -1, -1);
        chk("done_count_after_rst", 32'(done_cnt - d0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
